// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY
    } state_e;

    localparam logic [15:0] NOP_DEFAULT = 16'h0000;

    // Byte-offset shift that turns a fetch byte address into a word index.
    function automatic int unsigned bytes_log2(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, no reset.
module instr_mem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming program-load port and a registered,
// stallable, flushable fetch port for the pipeline fetch stage.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned       DATA_W = 16,
    parameter int unsigned       DEPTH  = 16,
    parameter int unsigned       ADDR_W = 16,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              ready
);

    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       SH         = bytes_log2(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SH) - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);

    state_e            state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              load_done_q;

    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] idx_full;
    logic              fetch_legal;
    logic [DATA_W-1:0] mem_rdata;

    // load_start has priority, so a coincident word is dropped.
    assign mem_we      = (state_q == LOAD) && load_valid && !load_start;
    assign idx_full    = fetch_addr >> SH;
    assign fetch_legal = ((fetch_addr & ALIGN_MASK) == '0) &&
                         (idx_full < ADDR_W'(DEPTH));

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (ptr_q),
        .wdata_i (load_data),
        .raddr_i (idx_full[PTR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    // Load FSM: pointer, state and the one-cycle load_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                EMPTY, READY: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        ptr_q   <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        ptr_q <= '0;
                    end else if (load_valid) begin
                        if (load_last || (ptr_q == LAST_PTR)) begin
                            state_q     <= READY;
                            ptr_q       <= '0;
                            load_done_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Next fetch result: flush > stall > request while READY > idle.
    always_comb begin
        instr_d       = NOP;
        instr_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        if (flush) begin
            instr_d       = NOP;
            instr_valid_d = 1'b0;
            addr_err_d    = 1'b0;
        end else if (stall) begin
            instr_d       = instr_q;
            instr_valid_d = instr_valid_q;
            addr_err_d    = addr_err_q;
        end else if (fetch_req && (state_q == READY)) begin
            instr_valid_d = 1'b1;
            if (fetch_legal) begin
                instr_d = mem_rdata;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    // Fetch output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q       <= NOP;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;
    assign load_done   = load_done_q;
    assign load_ready  = (state_q == LOAD);
    assign ready       = (state_q == READY);

endmodule
